// File: rtl/cdm16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cdm16_seq_ctrl
// Purpose  : 16x16 multiply sequencer that time-shares one external 8x8
//            multiplier over four byte steps (LL, HL, LH, HH) and combines
//            the partial products either exactly or lane-wise (no carry
//            between byte lanes).
// Revision : 1.0 - initial release
// ============================================================================
module cdm16_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_approx,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_lsb,
  input  logic [15:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_HL   = 3'd2,
    S_LH   = 3'd3,
    S_HH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Last wait-counter value of a step; the core product is sampled there.
  localparam logic [1:0] c_last_wait = 2'(MUL_LAT);

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        approx_q, approx_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic        mul_lsb_q, mul_lsb_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_r_q, out_r_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;

  logic [31:0] exact_sum;
  logic [7:0]  lane0, lane1, lane2, lane3;
  logic [31:0] step_acc;
  logic        step_last;

  assign step_last = (wcnt_q == c_last_wait);

  // Accumulator value after folding in the current step's partial product.
  always_comb begin
    exact_sum = acc_q;
    lane0     = acc_q[7:0];
    lane1     = acc_q[15:8];
    lane2     = acc_q[23:16];
    lane3     = acc_q[31:24];
    case (state_q)
      S_LL: begin
        exact_sum = acc_q + {16'd0, mul_p};
        lane0     = mul_p[7:0];
        lane1     = mul_p[15:8];
      end
      S_HL: begin
        exact_sum = acc_q + {8'd0, mul_p, 8'd0};
        lane1     = acc_q[15:8] + mul_p[7:0];
        lane2     = mul_p[15:8];
      end
      S_LH: begin
        exact_sum = acc_q + {8'd0, mul_p, 8'd0};
        lane1     = acc_q[15:8] + mul_p[7:0];
        lane2     = acc_q[23:16] + mul_p[15:8];
      end
      S_HH: begin
        exact_sum = acc_q + {mul_p, 16'd0};
        lane2     = acc_q[23:16] + mul_p[7:0];
        lane3     = mul_p[15:8];
      end
      default: begin
        exact_sum = acc_q;
      end
    endcase
    step_acc = approx_q ? {lane3, lane2, lane1, lane0} : exact_sum;
  end

  // Sequencer next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    approx_d    = approx_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_lsb_d   = mul_lsb_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = in_b;
          approx_d   = in_approx;
          acc_d      = 32'd0;
          wcnt_d     = 2'd0;
          mul_a_d    = in_a[7:0];
          mul_b_d    = in_b[7:0];
          mul_lsb_d  = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_LL;
        end
      end
      S_LL, S_HL, S_LH, S_HH: begin
        if (step_last) begin
          wcnt_d    = 2'd0;
          acc_d     = step_acc;
          mul_lsb_d = 1'b0;
          case (state_q)
            S_LL: begin
              mul_a_d = a_q[15:8];
              mul_b_d = b_q[7:0];
              state_d = S_HL;
            end
            S_HL: begin
              mul_a_d = a_q[7:0];
              mul_b_d = b_q[15:8];
              state_d = S_LH;
            end
            S_LH: begin
              mul_a_d = a_q[15:8];
              mul_b_d = b_q[15:8];
              state_d = S_HH;
            end
            default: begin
              mul_a_d     = 8'd0;
              mul_b_d     = 8'd0;
              out_r_d     = step_acc;
              out_valid_d = 1'b1;
              state_d     = S_DONE;
            end
          endcase
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        mul_a_d     = 8'd0;
        mul_b_d     = 8'd0;
        mul_lsb_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      approx_q    <= 1'b0;
      acc_q       <= 32'd0;
      wcnt_q      <= 2'd0;
      mul_a_q     <= 8'd0;
      mul_b_q     <= 8'd0;
      mul_lsb_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= 32'd0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      approx_q    <= approx_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_lsb_q   <= mul_lsb_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_lsb   = mul_lsb_q;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
